// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared state encoding and default widths for the down-counter
//               timer and its tick prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    localparam int C_DEFAULT_WIDTH          = 16;
    localparam int C_DEFAULT_PRESCALE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Enabled up-counter that emits a tick every prescale+1 enabled
//               clocks; clear forces the count back to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE_WIDTH = C_DEFAULT_PRESCALE_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] r_count;
    logic                      w_match;

    // Matching at all-ones too keeps a lowered prescale from stalling the timer.
    assign w_match = (r_count == prescale) || (r_count == {PRESCALE_WIDTH{1'b1}});
    assign tick    = enable && !clear && w_match;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear || tick) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_timer
// Description : Loadable prescaled down-counter with one-shot / auto-reload
//               modes, terminal-count pulse and sticky done flag.
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter_timer
    import timer_pkg::*;
#(
    parameter int WIDTH          = C_DEFAULT_WIDTH,
    parameter int PRESCALE_WIDTH = C_DEFAULT_PRESCALE_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      auto_reload,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]          count,
    output logic                      busy,
    output logic                      tc_pulse,
    output logic                      done
);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic             r_done, w_done_nxt;
    logic             r_tc, w_tc_nxt;
    logic             w_tick;
    logic             w_pre_clear;

    assign w_pre_clear = (r_state != RUN) || stop;

    tick_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (enable && (r_state == RUN)),
        .clear    (w_pre_clear),
        .prescale (prescale),
        .tick     (w_tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_done   <= w_done_nxt;
            r_tc     <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_done_nxt   = r_done;
        w_tc_nxt     = 1'b0;

        if (stop) begin
            if (r_state == RUN) begin
                w_state_nxt = IDLE;
            end
        end else begin
            if (load) begin
                w_reload_nxt = load_value;
                if (r_state != RUN) begin
                    w_count_nxt = load_value;
                    w_done_nxt  = 1'b0;
                end
            end

            if (r_state == RUN) begin
                if (w_tick) begin
                    if (r_count != '0) begin
                        w_count_nxt = r_count - 1'b1;
                        if (r_count == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                            w_tc_nxt = 1'b1;
                            if (!auto_reload) begin
                                w_state_nxt = DONE;
                                w_done_nxt  = 1'b1;
                            end
                        end
                    end else if (auto_reload) begin
                        // Reload uses the register value from before any same-cycle load.
                        w_count_nxt = r_reload;
                        w_tc_nxt    = (r_reload == '0);
                    end else begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end else if (start) begin
                // Decisions use the post-load values so load+start behaves as one write.
                w_done_nxt = 1'b0;
                if (w_count_nxt != '0) begin
                    w_state_nxt = RUN;
                end else if (w_reload_nxt != '0) begin
                    w_count_nxt = w_reload_nxt;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                    w_tc_nxt    = 1'b1;
                end
            end
        end
    end

    assign count    = r_count;
    assign busy     = (r_state == RUN);
    assign tc_pulse = r_tc;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_down_counter_timer
// Description : Directed self-checking bench for down_counter_timer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter_timer;

    localparam int C_WIDTH  = 16;
    localparam int C_PWIDTH = 8;

    logic                clock;
    logic                reset_n;
    logic                enable;
    logic                load;
    logic [C_WIDTH-1:0]  load_value;
    logic                start;
    logic                stop;
    logic                auto_reload;
    logic [C_PWIDTH-1:0] prescale;
    logic [C_WIDTH-1:0]  count;
    logic                busy;
    logic                tc_pulse;
    logic                done;

    int n_checks = 0;
    int n_fail   = 0;

    down_counter_timer #(
        .WIDTH          (C_WIDTH),
        .PRESCALE_WIDTH (C_PWIDTH)
    ) u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .prescale    (prescale),
        .count       (count),
        .busy        (busy),
        .tc_pulse    (tc_pulse),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs(input string tag, input int exp_count, input bit exp_busy,
                                 input bit exp_tc, input bit exp_done);
        check_value({tag, ".count"}, 32'(count), 32'(exp_count));
        check_value({tag, ".busy"},  32'(busy),  32'(exp_busy));
        check_value({tag, ".tc"},    32'(tc_pulse), 32'(exp_tc));
        check_value({tag, ".done"},  32'(done),  32'(exp_done));
    endtask

    int seq_ar [3] = '{2, 1, 0};
    int tc_seen;

    initial begin
        reset_n = 1'b0; enable = 1'b0; load = 1'b0; load_value = '0;
        start = 1'b0; stop = 1'b0; auto_reload = 1'b0; prescale = '0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        check_outputs("reset", 0, 0, 0, 0);

        // One-shot, prescale 0: 3,2,1,0 on successive cycles
        enable = 1'b1; load = 1'b1; load_value = 16'd3; start = 1'b1;
        step(); load = 1'b0; start = 1'b0;
        check_outputs("os3", 3, 1, 0, 0);
        step(); check_outputs("os2", 2, 1, 0, 0);
        step(); check_outputs("os1", 1, 1, 0, 0);
        step(); check_outputs("os0", 0, 0, 1, 1);
        step(); check_outputs("os_after", 0, 0, 0, 1);

        // Auto-reload, prescale 3: count moves every 4 clocks, pulse every 12
        prescale = 8'd3; auto_reload = 1'b1;
        load = 1'b1; load_value = 16'd2; start = 1'b1;
        step(); load = 1'b0; start = 1'b0;
        check_outputs("ar_start", 2, 1, 0, 0);
        tc_seen = 0;
        for (int i = 1; i <= 24; i++) begin
            step();
            check_value("ar.count", 32'(count), 32'(seq_ar[(i / 4) % 3]));
            check_value("ar.tc", 32'(tc_pulse),
                        32'(((i % 4) == 0) && (seq_ar[(i / 4) % 3] == 0)));
            if (tc_pulse) tc_seen++;
        end
        check_value("ar.tc_total", 32'(tc_seen), 32'd2);
        stop = 1'b1; step(); stop = 1'b0;
        check_outputs("ar_stop", 2, 0, 0, 0);

        // Freeze with enable low at count 7, then resume and stop at 4
        prescale = 8'd1; auto_reload = 1'b0;
        load = 1'b1; load_value = 16'd8; start = 1'b1;
        step(); load = 1'b0; start = 1'b0;
        check_outputs("fr_start", 8, 1, 0, 0);
        step(); step();
        check_outputs("fr_at7", 7, 1, 0, 0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_value("fr_hold.count", 32'(count), 32'd7);
            check_value("fr_hold.tc", 32'(tc_pulse), 32'd0);
        end
        enable = 1'b1;
        step(); check_value("fr_resume1", 32'(count), 32'd7);
        step(); check_value("fr_resume2", 32'(count), 32'd6);
        step(); step(); step(); step();
        check_value("fr_at4", 32'(count), 32'd4);
        stop = 1'b1; step(); stop = 1'b0;
        check_outputs("fr_stop", 4, 0, 0, 0);
        step(); check_outputs("fr_idle_hold", 4, 0, 0, 0);

        // Load 9 during RUN only affects the next reload
        prescale = 8'd0; auto_reload = 1'b1;
        load = 1'b1; load_value = 16'd2; start = 1'b1;
        step(); start = 1'b0; load_value = 16'd9;
        check_value("ld_start", 32'(count), 32'd2);
        step(); load = 1'b0;
        check_value("ld_inrun", 32'(count), 32'd1);
        step(); check_outputs("ld_zero", 0, 1, 1, 0);
        step(); check_outputs("ld_reload", 9, 1, 0, 0);
        step(); check_value("ld_dec", 32'(count), 32'd8);
        stop = 1'b1; step(); stop = 1'b0;
        check_outputs("ld_stop", 8, 0, 0, 0);

        // Start with count 0 and reload 0 goes straight to DONE with a pulse
        load = 1'b1; load_value = 16'd0;
        step(); load = 1'b0;
        check_outputs("z_load", 0, 0, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        check_value("z_start.tc", 32'(tc_pulse), 32'd1);
        check_value("z_start.busy", 32'(busy), 32'd0);
        check_value("z_start.count", 32'(count), 32'd0);
        step(); check_value("z_after.tc", 32'(tc_pulse), 32'd0);

        // Load in DONE clears done; stop+start in IDLE stays IDLE
        load = 1'b1; load_value = 16'd5;
        step(); load = 1'b0;
        check_outputs("sd_load", 5, 0, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        check_value("sd_run", 32'(busy), 32'd1);
        stop = 1'b1; step();
        check_outputs("sd_idle", 5, 0, 0, 0);
        start = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check_outputs("sd_stopstart", 5, 0, 0, 0);
        step(); check_value("sd_still_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-RUN with count 5
        prescale = 8'd7; auto_reload = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        check_outputs("rs_run", 5, 1, 0, 0);
        #2 reset_n = 1'b0;
        #1 check_outputs("rs_async", 0, 0, 0, 0);
        step(); #1 reset_n = 1'b1;
        step(); check_outputs("rs_after", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
